sdram_word_port: RTL and testbench
==================================

Name: sdram_word_port

Overview:
- Client-side adapter upstream of the byte-based, non-bursting SDRAM controller.
- Accepts 32-bit word read/write requests with per-byte enables over a valid/ready handshake.
- Reads: one controller read, returning the full 32-bit word.
- Writes: one controller byte write per enabled lane, then a single completion response.

Parameters:
- ADDR_WIDTH, 23: controller byte-address width; word address is ADDR_WIDTH-2 bits.
- DATA_WIDTH, 32: word width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  system clock (same clock as controller logic side).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge where req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH-2  word address.
- req_wdata  in  32  write data; lane n = bits [8n+7:8n].
- req_be  in  4  write byte enables; ignored for reads.
- resp_valid  out  1  one-cycle completion pulse (reads and writes).
- resp_rdata  out  32  read word; held until the next read completes.
- mem_rd  out  1  controller read command pulse (registered).
- mem_wr  out  1  controller write command pulse (registered).
- mem_addr  out  ADDR_WIDTH  controller byte address (registered).
- mem_din  out  8  controller write byte (registered).
- mem_dout32  in  32  controller 32-bit read data.
- mem_data_ready  in  1  controller read-data-valid pulse.
- mem_busy  in  1  controller busy; 0 = ready to take a command.

Behaviour:
- Reset values: state IDLE, req_ready=1 (combinational from IDLE), resp_valid=0, resp_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_din=0.
- Reset mid-operation: abandons the access and returns to IDLE; no resp_valid. The controller is reset by the same reset.
- Latched at acceptance: we, addr, wdata, be. Later changes on req_* are ignored.
- States:
  - IDLE: on accept go to ISSUE. If we=1 and be=0, instead set resp_valid<=1, stay IDLE, issue no memory access.
  - ISSUE: wait until mem_busy=0 (covers init/config and refresh). Then pulse mem_rd or mem_wr for exactly one cycle and go to GUARD.
    - Read: mem_addr={addr,2'b00}.
    - Write: lane = lowest set bit of the remaining be; mem_addr={addr,lane}; mem_din = that lane's byte. Clear that lane from the remaining mask.
  - GUARD: one cycle; deassert mem_rd/mem_wr; go to WAIT. This covers the one-cycle delay before the controller raises busy.
  - WAIT: when mem_busy=0:
    - Read, or write with remaining mask empty: resp_valid<=1, go to IDLE.
    - Write with lanes remaining: issue the next lane directly, as in ISSUE, and go to GUARD.
- resp_rdata <= mem_dout32 on any cycle where mem_data_ready=1 and the current op is a read.
- Ordering:
  - Lanes are written in ascending order 0→3.
  - At most one controller command is outstanding.
  - mem_rd and mem_wr are never both high.
- resp_valid is high in the first IDLE cycle after completion; a new request may be accepted in that same cycle.
- Latency with default controller timing and mem_busy=0 at first issue:
  - Acceptance at edge A; first command pulse after edge A+1.
  - Each access is 7 cycles from issue to observed completion.
  - Read: resp_valid high after edge A+8.
  - Write of k enabled lanes: resp_valid high after edge A+1+7k (k=4 → A+29).
- A refresh or a busy controller only stretches ISSUE/WAIT; there is no timeout.

Test Plan:
- Reset, then a read request while controller config is still running (mem_busy=1) → req_ready=1 before the request; mem_rd is not pulsed until mem_busy=0; exactly one mem_rd pulse follows.
- Write addr=0x000010, wdata=0xA1B2C3D4, be=4'b1111 with mem_busy idle → four mem_wr pulses at mem_addr 0x40,0x41,0x42,0x43 with mem_din D4,C3,B2,A1; resp_valid after A+29. Then read of 0x000010 → resp_rdata=0xA1B2C3D4 after A+8.
- Write be=4'b0100, wdata=0x00EE0000 to addr 5 → a single mem_wr at mem_addr 0x16, mem_din=0xEE; resp_valid after A+8. Write with be=4'b0000 → no mem_wr; resp_valid the next cycle.
- Inject a 6-cycle refresh (mem_busy=1) between lane 1 and lane 2 of a full write → lane 2 issues only after mem_busy falls; byte order unchanged; one resp_valid.
- Back-to-back: hold req_valid high across two reads → second accepted in the resp_valid cycle of the first; resp_rdata updates only on mem_data_ready.
- Assert reset during WAIT of a 4-lane write after lane 1 → next cycle state IDLE, mem_wr=0, resp_valid never pulses, req_ready=1.

Source files
------------

// File: rtl/sdram_word_port.sv
// sdram_word_port: adapts 32-bit word requests with byte enables onto a byte-wide,
// non-bursting SDRAM controller. Reads are one controller read of the full word;
// writes are one controller byte write per enabled lane, in ascending lane order.
module sdram_word_port #(
  parameter int unsigned ADDR_WIDTH = 23,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-3:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout32,
  input  logic                  mem_data_ready,
  input  logic                  mem_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StGuard, StWait} state_e;

  state_e                state_q, state_d;
  logic                  we_q;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q, be_d;  // lanes still to be written
  logic [1:0]            lane;
  logic                  accept, empty_write, issue_go, done;
  logic                  resp_valid_d, mem_rd_d, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [7:0]            mem_din_d;

  assign req_ready   = (state_q == StIdle);
  assign accept      = req_valid & req_ready;
  assign empty_write = req_we && (req_be == 4'b0000);
  // WAIT either finishes the op or chains straight into the next lane.
  assign done        = (state_q == StWait) && !mem_busy && (!we_q || (be_q == 4'b0000));
  assign issue_go    = !mem_busy && ((state_q == StIssue) ||
                       ((state_q == StWait) && we_q && (be_q != 4'b0000)));

  // Lowest set bit of the remaining lane mask.
  always_comb begin
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (be_q[i]) lane = 2'(i);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !empty_write) state_d = StIssue;
      StIssue: if (!mem_busy) state_d = StGuard;
      StGuard: state_d = StWait;
      StWait:  if (!mem_busy) state_d = done ? StIdle : StGuard;
      default: state_d = StIdle;
    endcase
  end

  // Next values for the registered command/response outputs.
  always_comb begin
    resp_valid_d = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_din_d    = mem_din;
    be_d         = be_q;
    if (accept && empty_write) resp_valid_d = 1'b1;
    if (done) resp_valid_d = 1'b1;
    if (issue_go) begin
      if (we_q) begin
        mem_wr_d   = 1'b1;
        mem_addr_d = {addr_q, lane};
        mem_din_d  = wdata_q[{lane, 3'b000} +: 8];
        be_d       = be_q & ~(4'b0001 << lane);
      end else begin
        mem_rd_d   = 1'b1;
        mem_addr_d = {addr_q, 2'b00};
      end
    end
  end

  // Request capture at acceptance; remaining mask shrinks as lanes issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end else begin
      be_q    <= be_d;
    end
  end

  // Registered outputs and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 8'h00;
    end else begin
      resp_valid <= resp_valid_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_din    <= mem_din_d;
      if (mem_data_ready && !we_q && (state_q != StIdle)) resp_rdata <= mem_dout32;
    end
  end

endmodule

// File: tb/tb_sdram_word_port.sv
// Bench for sdram_word_port: byte-wide controller model with fixed 7-cycle access,
// command monitor, and a word-level reference memory.
module tb_sdram_word_port;
  localparam int unsigned AW = 23;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-3:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [31:0]   mem_dout32;
  logic          mem_data_ready;
  logic          mem_busy;
  logic          ext_busy = 1'b0;
  logic          ctrl_busy;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] ref_mem [0:63];

  assign mem_busy = ext_busy | ctrl_busy;

  sdram_word_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout32(mem_dout32), .mem_data_ready(mem_data_ready), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  // Controller model: takes a command, busy 5 cycles later-visible window, 7 cycles total.
  logic [7:0] cmem [0:255];
  int         ctrl_cnt;
  logic       ctrl_rd;
  logic [7:0] ctrl_a;
  always @(posedge clk) begin
    if (reset) begin
      ctrl_busy <= 1'b0; ctrl_cnt <= 0; ctrl_rd <= 1'b0; ctrl_a <= 8'h00;
      mem_data_ready <= 1'b0; mem_dout32 <= 32'h0;
      for (int i = 0; i < 256; i++) cmem[i] <= 8'h00;
    end else begin
      mem_data_ready <= 1'b0;
      if (mem_rd || mem_wr) begin
        ctrl_busy <= 1'b1; ctrl_cnt <= 5; ctrl_rd <= mem_rd; ctrl_a <= mem_addr[7:0];
        if (mem_wr) cmem[mem_addr[7:0]] <= mem_din;
      end else if (ctrl_cnt == 1) begin
        ctrl_busy <= 1'b0; ctrl_cnt <= 0;
        if (ctrl_rd) begin
          mem_data_ready <= 1'b1;
          mem_dout32 <= {cmem[ctrl_a + 8'd3], cmem[ctrl_a + 8'd2], cmem[ctrl_a + 8'd1], cmem[ctrl_a]};
        end
      end else if (ctrl_cnt > 1) begin
        ctrl_cnt <= ctrl_cnt - 1;
      end
    end
  end

  // Command monitor: logs commands, flags issue-while-busy, stretched or overlapping pulses.
  logic [AW-1:0] wr_addr_q [$];
  logic [7:0]    wr_din_q [$];
  logic [AW-1:0] rd_addr_q [$];
  int   proto_err = 0;
  logic busy_prev = 1'b0;
  logic cmd_prev = 1'b0;
  always @(posedge clk) begin
    if (mem_wr) begin wr_addr_q.push_back(mem_addr); wr_din_q.push_back(mem_din); end
    if (mem_rd) rd_addr_q.push_back(mem_addr);
    if ((mem_rd || mem_wr) && (busy_prev || cmd_prev || (mem_rd && mem_wr) || ctrl_busy))
      proto_err <= proto_err + 1;
    busy_prev <= mem_busy;
    cmd_prev  <= mem_rd | mem_wr;
  end

  task automatic ref_write(input logic [AW-3:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int n = 0; n < 4; n++) if (be[n]) ref_mem[a[5:0]][8*n +: 8] = d[8*n +: 8];
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_din_q.delete(); rd_addr_q.delete();
  endtask

  // Drives one request from a negedge in IDLE; lat = edges after acceptance until resp_valid.
  task automatic run_txn(input logic we, input logic [AW-3:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int lat);
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = AW'($urandom) >> 2; req_wdata = $urandom;
    req_be = 4'($urandom);
    lat = -1;
    for (int m = 0; m < 300; m++) begin
      if (m > 0) @(negedge clk);
      if (resp_valid) begin lat = m; break; end
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1; ext_busy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if ({mem_rd, mem_wr} !== 2'b00) begin n_fail++; $display("FAIL reset_cmds: got rd=%b wr=%b want 0", mem_rd, mem_wr); end
    n_checks++; if (mem_addr !== '0 || mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_addr_din: got %h/%h want 0/0", mem_addr, mem_din); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    clear_logs();
    // Read accepted while controller config still holds busy.
    req_we = 1'b0; req_addr = 21'd3; req_valid = 1'b1;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (rd_addr_q.size() !== 0) begin n_fail++; $display("FAIL cfg_busy_no_rd: got %0d reads want 0", rd_addr_q.size()); end
    ext_busy = 1'b0;
    lat = -1;
    for (int m = 0; m < 50; m++) begin @(negedge clk); if (resp_valid) begin lat = m; break; end end
    n_checks++; if (lat < 0) begin n_fail++; $display("FAIL cfg_busy_resp: no resp_valid within 50 cycles"); end
    n_checks++; if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== 23'h0C) begin n_fail++; $display("FAIL cfg_busy_one_rd: got %0d reads want one at 0c", rd_addr_q.size()); end
    n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL cfg_proto: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_full_write_read();
    int lat;
    logic [7:0] exp_b [4];
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    clear_logs();
    run_txn(1'b1, 21'h10, 32'hA1B2C3D4, 4'b1111, lat);
    ref_write(21'h10, 32'hA1B2C3D4, 4'b1111);
    n_checks++; if (lat !== 29) begin n_fail++; $display("FAIL full_wr_latency: got %0d want 29", lat); end
    n_checks++; if (wr_addr_q.size() !== 4) begin n_fail++; $display("FAIL full_wr_count: got %0d want 4", wr_addr_q.size()); end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (n >= wr_addr_q.size() || wr_addr_q[n] !== 23'h40 + 23'(n) || wr_din_q[n] !== exp_b[n]) begin
        n_fail++; $display("FAIL full_wr_lane%0d: got %h/%h want %h/%h", n, wr_addr_q[n], wr_din_q[n], 23'h40 + 23'(n), exp_b[n]);
      end
    end
    clear_logs();
    run_txn(1'b0, 21'h10, 32'h0, 4'h0, lat);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL full_rd_latency: got %0d want 8", lat); end
    n_checks++; if (resp_rdata !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL full_rd_data: got %h want a1b2c3d4", resp_rdata); end
  endtask

  task automatic test_single_lane();
    int lat;
    clear_logs();
    run_txn(1'b1, 21'd5, 32'h00EE0000, 4'b0100, lat);
    ref_write(21'd5, 32'h00EE0000, 4'b0100);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL lane2_latency: got %0d want 8", lat); end
    n_checks++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 23'h16 || wr_din_q[0] !== 8'hEE) begin
      n_fail++; $display("FAIL lane2_cmd: got %0d writes first %h/%h want 1 at 16/ee", wr_addr_q.size(), wr_addr_q[0], wr_din_q[0]);
    end
    clear_logs();
    run_txn(1'b1, 21'd5, 32'hFFFFFFFF, 4'b0000, lat);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL empty_be_latency: got %0d want 0", lat); end
    @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL empty_be_nowrite: got %0d writes ready=%b want 0/1", wr_addr_q.size(), req_ready); end
    run_txn(1'b0, 21'd5, 32'h0, 4'h0, lat);
    n_checks++; if (resp_rdata !== ref_mem[5]) begin n_fail++; $display("FAIL lane2_readback: got %h want %h", resp_rdata, ref_mem[5]); end
  endtask

  task automatic test_refresh();
    int lat, pulses;
    logic [31:0] d;
    d = $urandom;
    clear_logs();
    req_we = 1'b1; req_addr = 21'd7; req_wdata = d; req_be = 4'b1111; req_valid = 1'b1;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    lat = -1; pulses = 0;
    for (int m = 0; m <= 45; m++) begin
      if (m > 0) @(negedge clk);
      if (m == 12) ext_busy = 1'b1;
      if (m == 18) ext_busy = 1'b0;
      if (resp_valid) begin pulses++; if (lat < 0) lat = m; end
    end
    ref_write(21'd7, d, 4'b1111);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL refresh_latency: got %0d want 33", lat); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL refresh_resp_count: got %0d want 1", pulses); end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (n >= wr_addr_q.size() || wr_addr_q[n] !== 23'h1C + 23'(n) || wr_din_q[n] !== d[8*n +: 8]) begin
        n_fail++; $display("FAIL refresh_lane%0d: got %h/%h want %h/%h", n, wr_addr_q[n], wr_din_q[n], 23'h1C + 23'(n), d[8*n +: 8]);
      end
    end
    n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL refresh_proto: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    w1 = ref_mem[16]; w2 = ref_mem[5];
    clear_logs();
    req_we = 1'b0; req_addr = 21'h10; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_addr = 21'd5;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      if (m == 8) begin
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== w1) begin n_fail++; $display("FAIL b2b_first: got v=%b %h want 1 %h", resp_valid, resp_rdata, w1); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_resp: got %b want 1", req_ready); end
      end
      if (m == 9) begin
        n_checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got ready=%b v=%b want 0/0", req_ready, resp_valid); end
      end
      if (m == 16) begin
        n_checks++; if (resp_rdata !== w1) begin n_fail++; $display("FAIL b2b_rdata_hold: got %h want %h", resp_rdata, w1); end
      end
      if (m == 17) begin
        req_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== w2) begin n_fail++; $display("FAIL b2b_second: got v=%b %h want 1 %h", resp_valid, resp_rdata, w2); end
      end
    end
    n_checks++; if (rd_addr_q.size() !== 2 || rd_addr_q[0] !== 23'h40 || rd_addr_q[1] !== 23'h14) begin
      n_fail++; $display("FAIL b2b_rd_cmds: got %0d reads want 2 at 40,14", rd_addr_q.size());
    end
  endtask

  task automatic test_random();
    int lat, exp_lat, idx;
    logic we;
    logic [AW-3:0] a;
    logic [31:0] d;
    logic [3:0] be;
    for (int t = 0; t < 25; t++) begin
      we = 1'($urandom); a = AW'($urandom_range(0, 63)); d = $urandom; be = 4'($urandom);
      clear_logs();
      run_txn(we, a, d, be, lat);
      exp_lat = !we ? 8 : (be == 4'b0000) ? 0 : 1 + 7 * $countones(be);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, exp_lat); end
      if (we) begin
        ref_write(a, d, be);
        n_checks++; if (wr_addr_q.size() !== $countones(be)) begin n_fail++; $display("FAIL rand%0d_wr_count: got %0d want %0d", t, wr_addr_q.size(), $countones(be)); end
        idx = 0;
        for (int n = 0; n < 4; n++) begin
          if (be[n]) begin
            n_checks++;
            if (idx >= wr_addr_q.size() || wr_addr_q[idx] !== {a, n[1:0]} || wr_din_q[idx] !== d[8*n +: 8]) begin
              n_fail++; $display("FAIL rand%0d_lane%0d: got %h/%h want %h/%h", t, n, wr_addr_q[idx], wr_din_q[idx], {a, n[1:0]}, d[8*n +: 8]);
            end
            idx++;
          end
        end
      end else begin
        n_checks++; if (resp_rdata !== ref_mem[a[5:0]]) begin n_fail++; $display("FAIL rand%0d_rdata: got %h want %h", t, resp_rdata, ref_mem[a[5:0]]); end
        n_checks++; if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== {a, 2'b00}) begin n_fail++; $display("FAIL rand%0d_rd_cmd: got %0d reads want 1 at %h", t, rd_addr_q.size(), {a, 2'b00}); end
      end
    end
    n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL rand_proto: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_reset_mid_write();
    int pulses, lat;
    clear_logs();
    req_we = 1'b1; req_addr = 21'd9; req_wdata = $urandom; req_be = 4'b1111; req_valid = 1'b1;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    n_checks++; if (req_ready !== 1'b1 || mem_wr !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got ready=%b wr=%b v=%b want 1/0/0", req_ready, mem_wr, resp_valid);
    end
    n_checks++; if (wr_addr_q.size() !== 2) begin n_fail++; $display("FAIL midreset_lanes: got %0d writes want 2", wr_addr_q.size()); end
    pulses = 0;
    repeat (40) begin @(negedge clk); if (resp_valid || mem_wr) pulses++; end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d resp/wr cycles want 0", pulses); end
    run_txn(1'b0, 21'd9, 32'h0, 4'h0, lat);
    n_checks++; if (lat !== 8 || resp_rdata !== ref_mem[9]) begin n_fail++; $display("FAIL midreset_read: got lat %0d %h want 8 %h", lat, resp_rdata, ref_mem[9]); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_full_write_read();
    test_single_lane();
    test_refresh();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
